mil_tx_sched: RTL and testbench
===============================

Name: mil_tx_sched

Overview:
Message sequencer for the Manchester serial word transmitter (MIL_TXD).
- Host loads one command word plus up to DEPTH-1 data words into an internal FIFO, then issues go.
- The block drives the transmitter's txen/dat so the whole message goes out as one continuous frame: first word with command sync, following words with data sync.
- After the frame it enforces a minimum inter-message gap, then reports completion.

Parameters:
DEPTH, 32, FIFO depth in 16-bit words; power of two, 2..32.
GAP_BITS, 4, minimum idle bit-times (tx_ce pulses) after tx_en falls before a new message may start.

Ports:
clk  in  1  system clock (same domain as the transmitter)
rst  in  1  reset; synchronous, active-high
wr_en  in  1  host FIFO write strobe
wr_dat  in  16  host FIFO write data (first word of a message = command word)
full  out  1  FIFO full; writes while full are ignored
level  out  6  FIFO occupancy, 0..DEPTH
go  in  1  single-cycle message start request
msg_len  in  6  words in the message incl. command word, 1..DEPTH; sampled on an accepted go
busy  out  1  message in progress, gap running, or transmitter still active
done  out  1  one-clk pulse when the gap after a good message expires
err  out  1  one-clk pulse on underrun or illegal msg_len
tx_txen  out  1  to transmitter txen
tx_dat  out  16  to transmitter dat
tx_en  in  1  from transmitter en_tx
tx_ce  in  1  from transmitter ce_tact (one clk per bit time)
tx_bit  in  5  from transmitter cb_bit (0..19 within a word)
tx_end  in  1  from transmitter T_end

Behaviour:
- Reset values: tx_txen=0, tx_dat=0, busy=0, done=0, err=0, FIFO empty (level=0, full=0), state IDLE.
- FIFO: synchronous write, first-word-fall-through. tx_dat always equals the head word, or 0 when empty.
  - Pop is internal only, one per transmitted word.
  - Simultaneous write and pop: level unchanged. Write-while-full is dropped; level stays DEPTH.
- Word latch point: the transmitter latches dat on the tx_ce where tx_bit==2 && tx_en. Call this event L.
  - Each L pops the head, decrements the words-remaining counter rem, and presents the next word for the next L.
- State IDLE:
  - go accepted only if !busy.
  - msg_len==0 or msg_len>DEPTH: err pulse, stay IDLE.
  - Otherwise rem<=msg_len, go to START.
  - go while busy is ignored; no err.
- START: tx_txen=1. Wait for tx_en rising, then go to SEND.
  - If level==0 when tx_en rises: underrun.
- SEND: tx_txen=1. On each L, rem decrements.
  - L with rem==1 (last word latched): tx_txen<=0 on the next clk, go to DRAIN.
  - tx_txen must be low ≥2 tx_ce pulses before the last word's tx_end so the transmitter ends the frame.
  - Before any L other than the last, if level==0: underrun.
- DRAIN: tx_txen=0. On tx_en falling, gap counter <=0, go to GAP.
- GAP: count tx_ce pulses. At GAP_BITS, go to IDLE and pulse done (done only if no underrun occurred).
- Underrun:
  - Takes effect immediately: tx_txen<=0, err pulse, go to DRAIN.
  - The transmitter completes the current word with stale data.
  - Remaining FIFO contents are kept.
- busy = (state!=IDLE) | tx_en.
- Reset mid-message: tx_txen drops the clk after rst. The transmitter is not reset; it closes its frame at the next tx_end. busy stays high until tx_en falls, so no go is accepted meanwhile.
- Latency: go to tx_txen=1 is 1 clk. Frame length is msg_len×20 bit-times plus the transmitter start overhead.

Test Plan:
- Load 0x8421, 0x0001, 0x00FF; go with msg_len=3 -> one continuous frame, words in order, first with command sync; tx_txen falls after the 3rd L; tx_en falls after 60 bit-times of words; done pulses GAP_BITS tx_ce later; level=0.
- msg_len=1, FIFO holds 0xFFFF -> single command word, tx_txen low from tx_bit 3 of that word, frame ends at its tx_end, done=1.
- msg_len=4, only 2 words loaded -> err pulse at the 2nd L, tx_txen=0, frame ends after word 2, no done, level=0.
- msg_len=0, then msg_len=33 with DEPTH=32 -> err pulse each time, tx_txen stays 0, busy stays 0.
- Write 33 words to DEPTH=32 -> full=1 after the 32nd write, 33rd dropped, level=32. Write during an L pop -> level unchanged.
- rst mid-word-2 of a 5-word message -> tx_txen=0 next clk, level=0, busy high until tx_en falls; go during that window is ignored; go after it starts a new message normally.

Source files
------------

// File: rtl/mil_tx_sched.sv
// ---------------------------------------------------------------------------
// mil_tx_sched
//
// Message sequencer in front of the MIL_TXD Manchester word transmitter.
// The host fills a first-word-fall-through FIFO with one command word and
// any number of data words, then pulses go with the message length. The
// block holds the transmitter's txen high so that all words leave as one
// continuous frame. The transmitter itself chooses command sync for the
// first word of a frame and data sync for the words that follow. After
// the frame closes, a minimum idle gap is enforced before done is pulsed.
//
// Parameters
//   DEPTH     FIFO depth in 16-bit words (power of two, 2..32)
//   GAP_BITS  idle bit-times (tx_ce pulses) required after tx_en falls (>=1)
//
// Ports
//   clk      in   system clock, shared with the transmitter
//   rst      in   synchronous active-high reset
//   wr_en    in   host FIFO write strobe
//   wr_dat   in   host FIFO write data (first word of a message = command)
//   full     out  FIFO full; writes while full are dropped
//   level    out  FIFO occupancy, 0..DEPTH
//   go       in   single-cycle message start request
//   msg_len  in   words in the message including the command word
//   busy     out  message running, gap running, or transmitter still active
//   done     out  one-clk pulse when the gap after a good message expires
//   err      out  one-clk pulse on underrun or illegal msg_len
//   tx_txen  out  transmitter txen
//   tx_dat   out  transmitter dat (FIFO head, 0 when empty)
//   tx_en    in   transmitter en_tx (frame active)
//   tx_ce    in   transmitter ce_tact (one clk per bit time)
//   tx_bit   in   transmitter cb_bit (0..19 within a word)
//   tx_end   in   transmitter T_end
// ---------------------------------------------------------------------------
module mil_tx_sched #(
    parameter int DEPTH    = 32,
    parameter int GAP_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_dat,
    output logic        full,
    output logic [5:0]  level,
    input  logic        go,
    input  logic [5:0]  msg_len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        tx_txen,
    output logic [15:0] tx_dat,
    input  logic        tx_en,
    input  logic        tx_ce,
    input  logic [4:0]  tx_bit,
    input  logic        tx_end
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [6:0] DEPTH_W  = 7'(DEPTH);
    localparam logic [5:0] DEPTH_L  = 6'(DEPTH);
    localparam logic [7:0] GAP_LAST = 8'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        DRAIN,
        GAP
    } state_t;

    state_t              state;
    logic [15:0]         mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [5:0]          count;
    logic [5:0]          count_next;
    logic [5:0]          rem;
    logic [7:0]          gap_cnt;
    logic                bad;
    logic                tx_en_q;
    logic                latch;
    logic                en_rise;
    logic                en_fall;
    logic                do_wr;
    logic                do_pop;

    // The end of a frame is observed through tx_en falling, so T_end
    // carries no extra information for this block.
    logic unused_inputs;
    assign unused_inputs = tx_end;

    // The transmitter samples dat on this bit-time; it is the only point
    // where a word is consumed.
    assign latch   = tx_ce & tx_en & (tx_bit == 5'd2);
    assign en_rise = tx_en & ~tx_en_q;
    assign en_fall = ~tx_en & tx_en_q;

    assign do_wr  = wr_en & ~full;
    assign do_pop = latch & (state == SEND) & (count != 6'd0);

    assign full   = (count == DEPTH_L);
    assign level  = count;
    assign tx_dat = (count == 6'd0) ? 16'h0000 : mem[rd_ptr];
    assign busy   = (state != IDLE) | tx_en;

    // Occupancy after this clock; a write and a pop together cancel.
    always_comb begin
        count_next = count;
        if (do_wr && !do_pop) begin
            count_next = count + 6'd1;
        end else if (!do_wr && do_pop) begin
            count_next = count - 6'd1;
        end
    end

    // FIFO storage has no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // FIFO pointers/occupancy and the delayed tx_en used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= 6'd0;
            tx_en_q <= 1'b0;
        end else begin
            tx_en_q <= tx_en;
            count   <= count_next;
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Message sequencer. An underrun drops txen at once so the transmitter
    // closes the frame after the word it is already sending; the gap is
    // still enforced, but done is suppressed for that message.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx_txen <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            rem     <= 6'd0;
            gap_cnt <= 8'd0;
            bad     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (go && !busy) begin
                        if (msg_len == 6'd0 || {1'b0, msg_len} > DEPTH_W) begin
                            err <= 1'b1;
                        end else begin
                            rem     <= msg_len;
                            bad     <= 1'b0;
                            tx_txen <= 1'b1;
                            state   <= START;
                        end
                    end
                end
                START: begin
                    if (en_rise) begin
                        if (count == 6'd0) begin
                            tx_txen <= 1'b0;
                            err     <= 1'b1;
                            bad     <= 1'b1;
                            state   <= DRAIN;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                SEND: begin
                    if (latch) begin
                        rem <= rem - 6'd1;
                        if (rem == 6'd1) begin
                            tx_txen <= 1'b0;
                            state   <= DRAIN;
                        end else if (count_next == 6'd0) begin
                            // Another word is still owed but nothing is left
                            // to present at the next latch point.
                            tx_txen <= 1'b0;
                            err     <= 1'b1;
                            bad     <= 1'b1;
                            state   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (en_fall) begin
                        gap_cnt <= 8'd0;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (tx_ce) begin
                        if (gap_cnt == GAP_LAST) begin
                            done  <= ~bad;
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    tx_txen <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mil_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_mil_tx_sched
//
// Self-checking bench for mil_tx_sched. A behavioural transmitter model
// produces tx_ce/tx_en/tx_bit/tx_end and records every word it latches,
// tagged with whether it is the first word of its frame (command sync).
// A queue models the host FIFO; expected words, errors and done pulses
// are derived from the queue contents and the requested message length.
// ---------------------------------------------------------------------------
module tb_mil_tx_sched;

    localparam int DEPTH    = 32;
    localparam int GAP_BITS = 4;
    localparam int CE_DIV   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_dat;
    logic        full;
    logic [5:0]  level;
    logic        go;
    logic [5:0]  msg_len;
    logic        busy;
    logic        done;
    logic        err;
    logic        tx_txen;
    logic [15:0] tx_dat;
    logic        tx_en  = 1'b0;
    logic        tx_ce  = 1'b0;
    logic [4:0]  tx_bit = 5'd0;
    logic        tx_end = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] fifo_q [$];
    logic [16:0] cap_q  [$];
    int          err_cnt   = 0;
    int          done_cnt  = 0;
    int          frame_cnt = 0;
    int          gap_ce    = 0;
    int          last_gap  = 0;
    int          ce_div    = 0;
    logic        txen_s    = 1'b0;
    logic        cont      = 1'b0;
    logic        first     = 1'b0;

    mil_tx_sched #(.DEPTH(DEPTH), .GAP_BITS(GAP_BITS)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_dat  (wr_dat),
        .full    (full),
        .level   (level),
        .go      (go),
        .msg_len (msg_len),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .tx_txen (tx_txen),
        .tx_dat  (tx_dat),
        .tx_en   (tx_en),
        .tx_ce   (tx_ce),
        .tx_bit  (tx_bit),
        .tx_end  (tx_end)
    );

    always #5 clk = ~clk;

    // Transmitter model, stepped on the falling edge. The ce pulse the DUT
    // just consumed advances the bit counter; the next pulse samples txen
    // and, at bit 2, latches the word on the dat bus.
    always @(negedge clk) begin
        if (tx_ce) begin
            if (!tx_en) begin
                gap_ce = gap_ce + 1;
                if (txen_s) begin
                    tx_en     = 1'b1;
                    tx_bit    = 5'd0;
                    first     = 1'b1;
                    frame_cnt = frame_cnt + 1;
                end
            end else begin
                if (tx_bit == 5'd17) begin
                    cont = txen_s;
                end
                if (tx_bit == 5'd19) begin
                    tx_bit = 5'd0;
                    if (cont) begin
                        first = 1'b0;
                    end else begin
                        tx_en  = 1'b0;
                        gap_ce = 0;
                    end
                end else begin
                    tx_bit = tx_bit + 5'd1;
                end
            end
        end
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            last_gap = gap_ce;
        end
        if (err === 1'b1) begin
            err_cnt = err_cnt + 1;
        end
        ce_div = (ce_div + 1) % CE_DIV;
        tx_ce  = (ce_div == 0);
        if (tx_ce) begin
            txen_s = tx_txen;
            if (tx_en && tx_bit == 5'd2) begin
                cap_q.push_back({first, tx_dat});
            end
        end
        tx_end = tx_ce & tx_en & (tx_bit == 5'd19);
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic write_word(input logic [15:0] w);
        wr_en  = 1'b1;
        wr_dat = w;
        if (fifo_q.size() < DEPTH) begin
            fifo_q.push_back(w);
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < 5000) begin
            tick();
            guard++;
        end
        if (guard >= 5000) begin
            checkOutput(tag, 32'd0, 32'd1);
        end
    endtask

    // Runs one message of len words and checks it against the FIFO model.
    // With wr_on_l set, a host write is issued in the same clock as the
    // first word latch.
    task automatic applyStimulus(input int len, input bit wr_on_l);
        int          base_cap;
        int          base_err;
        int          base_done;
        int          base_frame;
        int          n_exp;
        int          n_got;
        int          guard;
        bit          exp_err;
        bit          wrote;
        logic [5:0]  lvl;
        logic [16:0] e;
        logic [15:0] exp_w [$];

        exp_err = (fifo_q.size() < len);
        n_exp   = exp_err ? fifo_q.size() : len;
        for (int i = 0; i < n_exp; i++) begin
            exp_w.push_back(fifo_q.pop_front());
        end
        base_cap   = cap_q.size();
        base_err   = err_cnt;
        base_done  = done_cnt;
        base_frame = frame_cnt;
        wrote      = 1'b0;

        go      = 1'b1;
        msg_len = 6'(len);
        tick();
        go = 1'b0;
        checkOutput("go_latency", {31'd0, tx_txen}, 32'd1);

        guard = 0;
        while ((cap_q.size() - base_cap) < n_exp && guard < 20000) begin
            if (wr_on_l && !wrote && tx_ce && tx_en && tx_bit == 5'd2 && tx_txen) begin
                lvl    = level;
                wr_en  = 1'b1;
                wr_dat = 16'($urandom);
                if (fifo_q.size() < DEPTH) begin
                    fifo_q.push_back(wr_dat);
                end
                tick();
                wr_en = 1'b0;
                checkOutput("level_wr_pop", {26'd0, level}, {26'd0, lvl});
                wrote = 1'b1;
            end else begin
                tick();
            end
            guard++;
        end
        if (guard >= 20000) begin
            checkOutput("word_timeout", 32'd0, 32'd1);
        end

        guard = 0;
        while (!(tx_en && tx_bit == 5'd3) && guard < 200) begin
            tick();
            guard++;
        end
        checkOutput("txen_low_bit3", {31'd0, tx_txen}, 32'd0);

        wait_idle("idle_timeout");

        n_got = cap_q.size() - base_cap;
        checkOutput("word_count", n_got, n_exp);
        for (int i = 0; i < n_exp && i < n_got; i++) begin
            e = cap_q[base_cap + i];
            checkOutput("word_data", {16'd0, e[15:0]}, {16'd0, exp_w[i]});
            checkOutput("cmd_sync", {31'd0, e[16]}, (i == 0) ? 32'd1 : 32'd0);
        end
        checkOutput("frame_count", frame_cnt - base_frame, 32'd1);
        checkOutput("err_pulse", err_cnt - base_err, exp_err ? 32'd1 : 32'd0);
        checkOutput("done_pulse", done_cnt - base_done, exp_err ? 32'd0 : 32'd1);
        if (!exp_err) begin
            checkOutput("gap_len", last_gap, GAP_BITS);
        end
        checkOutput("level_after", {26'd0, level}, fifo_q.size());
        checkOutput("txen_idle", {31'd0, tx_txen}, 32'd0);
        checkOutput("head_word", {16'd0, tx_dat},
                    (fifo_q.size() > 0) ? {16'd0, fifo_q[0]} : 32'd0);
    endtask

    task automatic illegal_go(input int len);
        int base_err;
        base_err = err_cnt;
        go      = 1'b1;
        msg_len = 6'(len);
        tick();
        go = 1'b0;
        checkOutput("illegal_err", err_cnt - base_err, 32'd1);
        checkOutput("illegal_txen", {31'd0, tx_txen}, 32'd0);
        checkOutput("illegal_busy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("illegal_txen2", {31'd0, tx_txen}, 32'd0);
    endtask

    initial begin
        int base_cap;
        int base_err;
        int base_done;
        int guard;
        int k;
        int len;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_dat  = 16'h0;
        go      = 1'b0;
        msg_len = 6'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        checkOutput("rst_txen",  {31'd0, tx_txen}, 32'd0);
        checkOutput("rst_dat",   {16'd0, tx_dat}, 32'd0);
        checkOutput("rst_busy",  {31'd0, busy}, 32'd0);
        checkOutput("rst_done",  {31'd0, done}, 32'd0);
        checkOutput("rst_err",   {31'd0, err}, 32'd0);
        checkOutput("rst_level", {26'd0, level}, 32'd0);
        checkOutput("rst_full",  {31'd0, full}, 32'd0);

        // Three-word message.
        write_word(16'h8421);
        write_word(16'h0001);
        write_word(16'h00FF);
        checkOutput("fwft_head", {16'd0, tx_dat}, 32'h8421);
        checkOutput("level_3", {26'd0, level}, 32'd3);
        applyStimulus(3, 1'b0);

        // Single command word.
        write_word(16'hFFFF);
        applyStimulus(1, 1'b0);

        // Underrun: four words requested, two available.
        write_word(16'h1234);
        write_word(16'hABCD);
        applyStimulus(4, 1'b0);

        // Illegal lengths.
        illegal_go(0);
        illegal_go(33);

        // Fill past capacity, then send the whole FIFO.
        for (int i = 0; i < 33; i++) begin
            write_word(16'($urandom));
            if (i == 31) begin
                checkOutput("full_at_32", {31'd0, full}, 32'd1);
            end
        end
        checkOutput("level_full", {26'd0, level}, 32'd32);
        checkOutput("full_held", {31'd0, full}, 32'd1);
        applyStimulus(32, 1'b0);

        // Host write in the same clock as a word latch.
        write_word(16'hA5A5);
        write_word(16'h5A5A);
        write_word(16'h0F0F);
        applyStimulus(2, 1'b1);
        applyStimulus(2, 1'b0);

        // Reset during the second word of a five-word message.
        for (int i = 0; i < 5; i++) begin
            write_word(16'($urandom));
        end
        base_cap = cap_q.size();
        go      = 1'b1;
        msg_len = 6'd5;
        tick();
        go = 1'b0;
        guard = 0;
        while ((cap_q.size() - base_cap) < 2 && guard < 2000) begin
            tick();
            guard++;
        end
        if (guard >= 2000) begin
            checkOutput("rst_mid_timeout", 32'd0, 32'd1);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fifo_q.delete();
        checkOutput("rst_mid_txen", {31'd0, tx_txen}, 32'd0);
        checkOutput("rst_mid_level", {26'd0, level}, 32'd0);
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd1);
        base_err  = err_cnt;
        base_done = done_cnt;
        go      = 1'b1;
        msg_len = 6'd1;
        tick();
        go = 1'b0;
        tick();
        checkOutput("go_ignored", {31'd0, tx_txen}, 32'd0);
        wait_idle("rst_idle_timeout");
        checkOutput("rst_no_err", err_cnt - base_err, 32'd0);
        checkOutput("rst_no_done", done_cnt - base_done, 32'd0);
        write_word(16'hC3C3);
        applyStimulus(1, 1'b0);

        // Randomised messages; some lengths exceed what was loaded.
        for (int it = 0; it < 12; it++) begin
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) begin
                write_word(16'($urandom));
            end
            len = $urandom_range(1, 8);
            applyStimulus(len, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
